// File: rtl/data_mem_stage_if.sv
// MEM-stage bus between the EX/MEM register side (master) and the data
// memory stage (slave).
//
// Handshake: a request (MemWriteM or MemtoRegM) is presented by the master.
// While StallM is high the master must hold every request field stable. The
// request is complete in the first cycle after it was presented in which
// StallM is low. That cycle is the DONE cycle, and ReadDataM is valid in it.
// A misaligned request is never stalled. Instead it raises MisalignM for the
// following cycle.
interface data_mem_stage_if;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;

  modport master (
    output ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
    input  ReadDataM, StallM, MisalignM
  );

  modport slave (
    input  ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
    output ReadDataM, StallM, MisalignM
  );
endinterface

// File: rtl/data_mem_stage.sv
// MEM-stage word data memory with a fixed access latency. An aligned access
// stalls the pipeline for exactly LAT cycles, then spends one DONE cycle
// unstalled. Stores take priority over loads when both flags are set.
module data_mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              rst,
  data_mem_stage_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mis_q, mis_d;
  logic               stall;
  logic               access;
  logic               mem_we;
  logic               req;
  logic               aligned;
  logic [ADDR_W-1:0]  idx;
  logic               unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign req     = bus.MemWriteM | bus.MemtoRegM;
  assign aligned = (bus.ALUOutM[1:0] == 2'b00);
  assign idx     = bus.ALUOutM[ADDR_W+1:2];
  // The upper address bits are dropped, so out-of-range addresses wrap.
  assign unused_addr_bits = ^bus.ALUOutM[31:ADDR_W+2];

  // Next-state, counter, result and stall decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    stall   = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && aligned) begin
          stall = 1'b1;
          if (LAT == 1) begin
            access  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(LAT - 2);
            state_d = BUSY;
          end
        end else if (req) begin
          mis_d = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A store wins over a load, so a dual-flag access leaves ReadDataM alone.
    if (access && !bus.MemWriteM && bus.MemtoRegM) begin
      rdata_d = mem[idx];
    end
  end

  // A reset landing on the completing edge must abort the store as well.
  assign mem_we = access & bus.MemWriteM & ~rst;

  // Control and result registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // RAM write port. The contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx] <= bus.WriteDataM;
    end
  end

  assign bus.StallM    = stall & ~rst;
  assign bus.ReadDataM = rdata_q;
  assign bus.MisalignM = mis_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- MEM-stage data memory for the 5-stage MIPS core, directly downstream of the EX/MEM pipeline register.
- Consumes ALUOutM (address), WriteDataM, MemWriteM and MemtoRegM.
- Performs word loads/stores against an internal word-addressed RAM with a fixed, parameterised access latency.
- While an access is in flight, it raises StallM so the hazard unit holds the IF/ID/EX/MEM registers. Loaded data goes to the MEM/WB register.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM.
- ADDR_W, 8, word-index width, equal to log2(DEPTH).
- LAT, 2, access latency in cycles. LAT >= 1; LAT = 0 is illegal.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ALUOutM  in  32  byte address from EX/MEM.
- WriteDataM  in  32  store data from EX/MEM.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  load request.
- ReadDataM  out  32  load result (registered).
- StallM  out  1  pipeline hold request.
- MisalignM  out  1  one-cycle misaligned-access flag (registered).

Behaviour:
- Reset: the one clock is CLK; reset is asynchronous and active-high on rst.
  - rst = 1 forces state IDLE, counter 0, ReadDataM 0, MisalignM 0, StallM 0.
  - RAM contents are not reset.
- Request: req = MemWriteM | MemtoRegM.
- Address: aligned = (ALUOutM[1:0] == 0). Word index = ALUOutM[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- FSM states are IDLE, BUSY and DONE. The counter is cnt, width clog2(LAT) with a minimum of 1.
- IDLE:
  - req & aligned: StallM = 1 combinationally in the same cycle.
    - If LAT = 1: perform the access at this edge and go to DONE.
    - Else: cnt <= LAT-2 and go to BUSY.
  - req & !aligned: no access, StallM = 0, MisalignM <= 1 for exactly one cycle, stay in IDLE.
  - !req: StallM = 0, MisalignM <= 0.
- BUSY:
  - StallM = 1. The inputs are guaranteed stable, because the upstream register is held.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: perform the access at this edge and go to DONE.
- Access:
  - Store: RAM[idx] <= WriteDataM.
  - Load: ReadDataM <= RAM[idx].
  - Both MemWriteM and MemtoRegM set: the store wins, no load is done, and ReadDataM is unchanged.
- DONE:
  - StallM = 0. The pipeline advances at this edge; go to IDLE unconditionally.
  - The next instruction is evaluated in the following IDLE cycle.
  - A back-to-back request therefore gives LAT stall cycles, then 1 free cycle, then repeats.
- Timing: total StallM-high cycles per aligned access is exactly LAT. ReadDataM is valid in the DONE cycle.
- ReadDataM holds the last loaded value until the next completed load. It does not change on stores, misaligned requests or idle cycles.
- MisalignM is 0 in every cycle except the one following a misaligned request seen in IDLE.
- Reset mid-access (rst asserted in BUSY, or at the completing edge): the access is aborted, no RAM write occurs, and the outputs take their reset values immediately.
- Request deasserted while in BUSY is illegal; the design may ignore it. The access still completes using the current inputs.

Test Plan:
- Store then load, LAT = 2:
  - Store 0xDEADBEEF to address 0x10. StallM is high 2 cycles, then low 1 cycle.
  - Load from 0x10. After 2 stall cycles, ReadDataM = 0xDEADBEEF in the DONE cycle.
- Back-to-back loads, LAT = 3:
  - Loads from 0x00, then 0x04, holding each until DONE, with RAM preloaded 0x11111111 and 0x22222222.
  - StallM pattern is 1,1,1,0,1,1,1,0. ReadDataM = 0x11111111, then 0x22222222.
- Misaligned: load from 0x0000_0006.
  - StallM stays 0.
  - MisalignM = 1 for exactly one cycle.
  - ReadDataM unchanged.
  - No RAM location modified.
- Wrap-around, DEPTH = 256: store 0xA5A5A5A5 to 0x0000_0400, then load from 0x0000_0000 -> ReadDataM = 0xA5A5A5A5.
- Reset mid-store, LAT = 4:
  - Store 0x12345678 to 0x20 with RAM[8] = 0; assert rst in the 2nd BUSY cycle.
  - StallM drops to 0 asynchronously and the state returns to IDLE.
  - A later load of 0x20 returns 0.
- Both flags: MemWriteM = MemtoRegM = 1, address 0x08, data 0xCAFEF00D.
  - RAM[2] = 0xCAFEF00D.
  - ReadDataM keeps its previous value.
  - StallM is high for LAT cycles.
